password_lock_controller: RTL and testbench

PASSWORD_LOCK_CONTROLLER -- requirements
Module: password_lock_controller

---
 rtl/password_lock_controller_pkg.sv | 30 +++
 rtl/password_lock_controller_lock_timer.sv | 44 ++++
 rtl/password_lock_controller.sv | 234 +++++++++++++++++++++++
 tb/tb_password_lock_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/password_lock_controller_pkg.sv
// Shared constants and types for the password lock controller.
// Holds the parameter defaults (digit count/width, fail limit, timeouts,
// reset code), the FSM state encoding and a counter-width helper.
package password_lock_controller_pkg;

  localparam int unsigned NUM_DIGITS_DEF    = 4;
  localparam int unsigned DIGIT_W_DEF       = 4;
  localparam int unsigned MAX_FAILS_DEF     = 3;
  localparam int unsigned LOCK_CYCLES_DEF   = 1000;
  localparam int unsigned UNLOCK_CYCLES_DEF = 500;
  localparam logic [15:0] DEFAULT_CODE_DEF  = 16'h1234;

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_PROGRAM  = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold a down-counter starting at max_count-1.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/password_lock_controller_lock_timer.sv
// lock_timer: loadable down-counter that stops at zero.
// Ports:
//   new_clk    - clock
//   reset      - asynchronous active-high reset (count forced to 0)
//   load       - load load_value this cycle (wins over counting)
//   load_value - start value of the countdown
//   done       - high while the count is zero
module lock_timer
  import password_lock_controller_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic         new_clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;
  logic [W-1:0] count_nxt;

  // Next count: load has priority, otherwise decrement until zero.
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_value;
    end else if (count != '0) begin
      count_nxt = count - W'(1);
    end
  end

  // Counter and registered zero flag.
  always_ff @(posedge new_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b1;
    end else begin
      count <= count_nxt;
      done  <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/password_lock_controller.sv
// password_lock_controller: keypad code lock with lockout and code programming.
// Digits arrive one per enter_pulse; after NUM_DIGITS digits the buffer is
// compared with the stored code. A match unlocks for UNLOCK_CYCLES cycles,
// MAX_FAILS consecutive mismatches lock the keypad for LOCK_CYCLES cycles.
// While unlocked, enter_pulse with prog_req starts programming a new code.
// Ports:
//   new_clk     - clock
//   reset       - asynchronous active-high reset
//   enter_pulse - one-cycle digit strobe
//   digit_in    - digit value, sampled on enter_pulse
//   prog_req    - level request to reprogram (used only while unlocked)
//   digit_idx   - position of the next digit
//   unlocked    - high while unlocked
//   error       - one-cycle pulse per mismatch
//   locked_out  - high while locked out
//   prog_mode   - high while programming
//   fail_count  - consecutive mismatch count (saturating, MAX_FAILS <= 3)
module password_lock_controller
  import password_lock_controller_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = NUM_DIGITS_DEF,
  parameter int unsigned DIGIT_W       = DIGIT_W_DEF,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = DEFAULT_CODE_DEF,
  parameter int unsigned MAX_FAILS     = MAX_FAILS_DEF,
  parameter int unsigned LOCK_CYCLES   = LOCK_CYCLES_DEF,
  parameter int unsigned UNLOCK_CYCLES = UNLOCK_CYCLES_DEF
) (
  input  logic               new_clk,
  input  logic               reset,
  input  logic               enter_pulse,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               prog_req,
  output logic [1:0]         digit_idx,
  output logic               unlocked,
  output logic               error,
  output logic               locked_out,
  output logic               prog_mode,
  output logic [1:0]         fail_count
);

  localparam int unsigned CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned TMR_W  = cnt_width(max_u(LOCK_CYCLES, UNLOCK_CYCLES));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t state;
  state_t next_state;

  logic [IDX_W-1:0]  idx;
  logic [CODE_W-1:0] entry_buf;
  logic [CODE_W-1:0] stage_buf;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] entry_upd;
  logic [CODE_W-1:0] stage_upd;

  logic              last_digit;
  logic              match;
  logic [1:0]        fail_inc;

  logic              timer_load;
  logic [TMR_W-1:0]  timer_value;
  logic              timer_done;

  logic              unlocked_d;
  logic              error_d;
  logic              locked_out_d;
  logic              prog_mode_d;
  logic [1:0]        fail_d;

  // Replace digit slot i of a packed code; slot 0 occupies the top bits.
  function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0] b,
                                                   input logic [IDX_W-1:0]  i,
                                                   input logic [DIGIT_W-1:0] d);
    logic [CODE_W-1:0] r;
    r = b;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (i == IDX_W'(k)) begin
        r[(NUM_DIGITS - 1 - k) * DIGIT_W +: DIGIT_W] = d;
      end
    end
    return r;
  endfunction

  assign last_digit = (idx == LAST_IDX);
  assign match      = (entry_buf == code);
  assign entry_upd  = put_digit(entry_buf, idx, digit_in);
  assign stage_upd  = put_digit(stage_buf, idx, digit_in);
  assign digit_idx  = 2'(idx);

  // Mismatch count after one more failure, saturating at MAX_FAILS.
  always_comb begin
    fail_inc = fail_count + 2'd1;
    if (({30'd0, fail_count} + 32'd1) >= MAX_FAILS) begin
      fail_inc = 2'(MAX_FAILS);
    end
  end

  lock_timer #(
    .W (TMR_W)
  ) u_lock_timer (
    .new_clk    (new_clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // State register.
  always_ff @(posedge new_clk or posedge reset) begin
    if (reset) begin
      state <= ST_ENTRY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_ENTRY: begin
        if (enter_pulse && last_digit) begin
          next_state = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (match) begin
          next_state = ST_UNLOCKED;
        end else if (fail_inc == 2'(MAX_FAILS)) begin
          next_state = ST_LOCKOUT;
        end else begin
          next_state = ST_ENTRY;
        end
      end
      ST_UNLOCKED: begin
        // A keypress beats the relock timeout in the same cycle.
        if (enter_pulse) begin
          next_state = prog_req ? ST_PROGRAM : ST_ENTRY;
        end else if (timer_done) begin
          next_state = ST_ENTRY;
        end
      end
      ST_PROGRAM: begin
        if (enter_pulse && last_digit) begin
          next_state = ST_ENTRY;
        end
      end
      ST_LOCKOUT: begin
        if (timer_done) begin
          next_state = ST_ENTRY;
        end
      end
      default: next_state = ST_ENTRY;
    endcase
  end

  // Output/timer-control logic; flag outputs follow the state being entered.
  always_comb begin
    unlocked_d   = (next_state == ST_UNLOCKED);
    locked_out_d = (next_state == ST_LOCKOUT);
    prog_mode_d  = (next_state == ST_PROGRAM);
    error_d      = (state == ST_CHECK) && !match;
    fail_d       = fail_count;
    if (state == ST_CHECK) begin
      fail_d = match ? 2'd0 : fail_inc;
    end else if (state == ST_LOCKOUT && next_state == ST_ENTRY) begin
      fail_d = 2'd0;
    end
    // Timer is reloaded on every state change; zero outside the timed states
    // keeps it idle in ENTRY and PROGRAM.
    timer_load  = (next_state != state);
    timer_value = '0;
    if (next_state == ST_UNLOCKED) begin
      timer_value = TMR_W'(UNLOCK_CYCLES - 1);
    end else if (next_state == ST_LOCKOUT) begin
      timer_value = TMR_W'(LOCK_CYCLES - 1);
    end
  end

  // Output registers.
  always_ff @(posedge new_clk or posedge reset) begin
    if (reset) begin
      unlocked   <= 1'b0;
      error      <= 1'b0;
      locked_out <= 1'b0;
      prog_mode  <= 1'b0;
      fail_count <= 2'd0;
    end else begin
      unlocked   <= unlocked_d;
      error      <= error_d;
      locked_out <= locked_out_d;
      prog_mode  <= prog_mode_d;
      fail_count <= fail_d;
    end
  end

  // Digit index, entry/staging buffers and stored code.
  always_ff @(posedge new_clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      entry_buf <= '0;
      stage_buf <= '0;
      code      <= DEFAULT_CODE;
    end else begin
      unique case (state)
        ST_ENTRY: begin
          if (enter_pulse) begin
            entry_buf <= entry_upd;
            idx       <= last_digit ? '0 : idx + IDX_W'(1);
          end
        end
        ST_CHECK: begin
          entry_buf <= '0;
        end
        ST_PROGRAM: begin
          if (enter_pulse) begin
            if (last_digit) begin
              code      <= stage_upd;
              stage_buf <= '0;
              idx       <= '0;
            end else begin
              stage_buf <= stage_upd;
              idx       <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_password_lock_controller.sv
// Self-checking bench for password_lock_controller: a vector table, directed
// timing sequences and a randomized run against a behavioural model.
module tb_password_lock_controller;

  localparam int UNLOCK_LEN = 500;
  localparam int LOCK_LEN   = 1000;
  localparam int FAIL_LIMIT = 3;

  logic       new_clk = 1'b0;
  logic       reset = 1'b0;
  logic       enter_pulse = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       prog_req = 1'b0;
  logic [1:0] digit_idx;
  logic       unlocked;
  logic       error;
  logic       locked_out;
  logic       prog_mode;
  logic [1:0] fail_count;

  int total = 0;
  int bad   = 0;

  password_lock_controller dut (
    .new_clk     (new_clk),
    .reset       (reset),
    .enter_pulse (enter_pulse),
    .digit_in    (digit_in),
    .prog_req    (prog_req),
    .digit_idx   (digit_idx),
    .unlocked    (unlocked),
    .error       (error),
    .locked_out  (locked_out),
    .prog_mode   (prog_mode),
    .fail_count  (fail_count)
  );

  always #5 new_clk = ~new_clk;

  logic [7:0] obs;
  assign obs = {digit_idx, unlocked, error, locked_out, prog_mode, fail_count};

  function automatic logic [7:0] o(int idx, bit u, bit e, bit l, bit p, int fc);
    return {2'(idx), u, e, l, p, 2'(fc)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge new_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enter_pulse = 1'b0; prog_req = 1'b0; digit_in = 4'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic press(input int d, input bit p);
    enter_pulse = 1'b1; digit_in = 4'(d); prog_req = p;
    tick();
    enter_pulse = 1'b0; prog_req = 1'b0;
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int e);
    press(a, 0); press(b, 0); press(c, 0); press(e, 0);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_TYPING, M_VERIFY, M_OPEN, M_PROG, M_BLOCKED} mmode_t;
  mmode_t m_mode;
  int     m_q[$];
  int     m_code[4];
  int     m_fails;
  int     m_left;
  bit     m_err;

  task automatic m_reset();
    m_mode = M_TYPING; m_q.delete(); m_fails = 0; m_left = 0; m_err = 0;
    m_code[0] = 1; m_code[1] = 2; m_code[2] = 3; m_code[3] = 4;
  endtask

  task automatic m_edge(input bit en, input int d, input bit p);
    bit ok;
    m_err = 0;
    case (m_mode)
      M_TYPING: if (en) begin
        m_q.push_back(d);
        if (m_q.size() == 4) m_mode = M_VERIFY;
      end
      M_VERIFY: begin
        ok = 1;
        for (int i = 0; i < 4; i++) if (m_q[i] != m_code[i]) ok = 0;
        m_q.delete();
        if (ok) begin
          m_mode = M_OPEN; m_fails = 0; m_left = UNLOCK_LEN;
        end else begin
          m_err = 1; m_fails++;
          if (m_fails >= FAIL_LIMIT) begin
            m_mode = M_BLOCKED; m_left = LOCK_LEN;
          end else begin
            m_mode = M_TYPING;
          end
        end
      end
      M_OPEN: begin
        if (en) m_mode = p ? M_PROG : M_TYPING;
        else begin
          m_left--;
          if (m_left == 0) m_mode = M_TYPING;
        end
      end
      M_PROG: if (en) begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_code[i] = m_q[i];
          m_q.delete();
          m_mode = M_TYPING;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_TYPING; m_fails = 0;
        end
      end
    endcase
  endtask

  function automatic logic [7:0] m_exp();
    int idx;
    idx = (m_mode == M_TYPING || m_mode == M_PROG) ? m_q.size() : 0;
    return o(idx, m_mode == M_OPEN, m_err, m_mode == M_BLOCKED, m_mode == M_PROG, m_fails);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst;
    bit         en;
    int         d;
    bit         prog;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit en, input int d, input bit p, input logic [7:0] e);
    vec_t v;
    v.rst = rst; v.en = en; v.d = d; v.prog = p; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    int d;
    bit en;
    bit p;
    bit r;

    // Reset, three wrong codes, lockout, reset, unlock, program 9876, verify.
    add(1, 0, 0, 0, o(0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      add(0, 1, 1, 0, o(1, 0, 0, 0, 0, k - 1));
      add(0, 1, 2, 0, o(2, 0, 0, 0, 0, k - 1));
      add(0, 1, 3, 0, o(3, 0, 0, 0, 0, k - 1));
      add(0, 1, 5, 0, o(0, 0, 0, 0, 0, k - 1));
      add(0, 0, 0, 0, o(0, 0, 1, (k == 3), 0, k));
      if (k < 3) add(0, 0, 0, 0, o(0, 0, 0, 0, 0, k));
    end
    add(0, 1, 1, 0, o(0, 0, 0, 1, 0, 3));
    add(1, 0, 0, 0, o(0, 0, 0, 0, 0, 0));
    add(0, 1, 1, 0, o(1, 0, 0, 0, 0, 0));
    add(0, 1, 2, 0, o(2, 0, 0, 0, 0, 0));
    add(0, 1, 3, 0, o(3, 0, 0, 0, 0, 0));
    add(0, 1, 4, 0, o(0, 0, 0, 0, 0, 0));
    add(0, 1, 7, 0, o(0, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, o(0, 1, 0, 0, 0, 0));
    add(0, 1, 0, 1, o(0, 0, 0, 0, 1, 0));
    add(0, 1, 9, 0, o(1, 0, 0, 0, 1, 0));
    add(0, 1, 8, 0, o(2, 0, 0, 0, 1, 0));
    add(0, 1, 7, 0, o(3, 0, 0, 0, 1, 0));
    add(0, 1, 6, 0, o(0, 0, 0, 0, 0, 0));
    add(0, 1, 1, 0, o(1, 0, 0, 0, 0, 0));
    add(0, 1, 2, 0, o(2, 0, 0, 0, 0, 0));
    add(0, 1, 3, 0, o(3, 0, 0, 0, 0, 0));
    add(0, 1, 4, 0, o(0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, o(0, 0, 1, 0, 0, 1));
    add(0, 1, 9, 0, o(1, 0, 0, 0, 0, 1));
    add(0, 1, 8, 0, o(2, 0, 0, 0, 0, 1));
    add(0, 1, 7, 0, o(3, 0, 0, 0, 0, 1));
    add(0, 1, 6, 0, o(0, 0, 0, 0, 0, 1));
    add(0, 0, 0, 0, o(0, 1, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; enter_pulse = tbl[i].en;
      digit_in = 4'(tbl[i].d); prog_req = tbl[i].prog;
      tick();
      chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].exp));
    end
    reset = 0; enter_pulse = 0; prog_req = 0;

    // Unlock two edges after the last digit, relock after exactly 500 cycles.
    do_reset();
    enter_code(1, 2, 3, 4);
    chk("unlock_not_yet", 32'(unlocked), 32'd0);
    tick();
    chk("unlock_edge2", 32'(unlocked), 32'd1);
    chk("unlock_fails0", 32'(fail_count), 32'd0);
    n = 0;
    while (unlocked === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    chk("unlock_length", 32'(n), 32'(UNLOCK_LEN));

    // Lockout ignores keys, lasts 1000 cycles, then 1234 unlocks.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      enter_code(1, 2, 3, 5);
      tick();
      chk("lo_err_pulse", 32'(error), 32'd1);
      chk("lo_fail_cnt", 32'(fail_count), 32'(k));
    end
    chk("lo_locked", 32'(locked_out), 32'd1);
    n = 1;
    for (int k = 0; k < 10; k++) begin
      press(k + 1, 0);
      chk("lo_idx_held", 32'(digit_idx), 32'd0);
      n++;
    end
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (locked_out !== 1'b1) break;
      n++;
    end
    chk("lo_length", 32'(n), 32'(LOCK_LEN));
    chk("lo_fails_clear", 32'(fail_count), 32'd0);
    enter_code(1, 2, 3, 4);
    tick();
    chk("lo_then_unlock", 32'(unlocked), 32'd1);

    // Async reset in the middle of programming discards the new code.
    do_reset();
    enter_code(1, 2, 3, 4);
    tick();
    press(0, 1);
    chk("pg_mode", 32'(prog_mode), 32'd1);
    press(9, 0);
    press(8, 0);
    chk("pg_idx2", 32'(digit_idx), 32'd2);
    #2 reset = 1'b1;
    #1 chk("pg_async_rst", 32'(obs), 32'd0);
    tick();
    reset = 1'b0;
    enter_code(9, 8, 7, 6);
    tick();
    chk("pg_partial_err", 32'(error), 32'd1);
    enter_code(1, 2, 3, 4);
    tick();
    chk("pg_default_code", 32'(unlocked), 32'd1);

    // Keypress with prog_req on the cycle the relock timeout expires.
    do_reset();
    enter_code(1, 2, 3, 4);
    tick();
    for (int k = 0; k < UNLOCK_LEN - 1; k++) tick();
    chk("race_still_open", 32'(unlocked), 32'd1);
    press(0, 1);
    chk("race_prog", 32'(prog_mode), 32'd1);
    chk("race_unl", 32'(unlocked), 32'd0);

    // Randomized run against the model.
    for (int c = 0; c < 20000; c++) begin
      r  = (c == 0) || ($urandom_range(0, 2999) == 0);
      en = ($urandom_range(0, 2) == 0);
      p  = $urandom_range(0, 1);
      if (m_mode == M_TYPING && m_q.size() < 4 && $urandom_range(0, 3) != 0)
        d = m_code[m_q.size()];
      else
        d = $urandom_range(0, 15);
      reset = r; enter_pulse = en; digit_in = 4'(d); prog_req = p;
      tick();
      if (r) m_reset();
      else m_edge(en, d, p);
      chk($sformatf("rand%0d", c), 32'(obs), 32'(m_exp()));
    end
    reset = 0; enter_pulse = 0; prog_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
